// File: rtl/conv_accum_requant.sv
// Output path of the convolution unit. Accumulates MAC partial sums over the
// input-channel tiles of each output pixel, adds bias, then requantises
// (rounding arithmetic right-shift, optional ReLU, int8 saturation) across
// OUT_CH channels in parallel. Tracks tiles per pixel and pixels per layer,
// and pulses state_end when the layer completes.
module conv_accum_requant #(
    parameter int OUT_CH         = 18,
    parameter int PSUM_WIDTH     = 20,
    parameter int ACC_WIDTH      = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int BIAS_WIDTH     = 16,
    parameter int SHIFT_WIDTH    = 5,
    parameter int TILE_CNT_WIDTH = 8,
    parameter int PIX_CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_start,
    input  logic [TILE_CNT_WIDTH-1:0]      cfg_tile_num,
    input  logic [PIX_CNT_WIDTH-1:0]       cfg_pix_num,
    input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
    input  logic                           cfg_relu_en,
    input  logic [OUT_CH*BIAS_WIDTH-1:0]   bias_in,
    input  logic [OUT_CH*PSUM_WIDTH-1:0]   psum_in,
    input  logic                           psum_valid_in,
    output logic [OUT_CH*DATA_WIDTH-1:0]   data_out,
    output logic                           data_valid_out,
    output logic                           busy,
    output logic                           state_end
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    // One extra bit of headroom so the rounding add cannot overflow.
    localparam logic signed [ACC_WIDTH:0] RND_ONE = 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

    state_t                      state;
    logic [TILE_CNT_WIDTH-1:0]   tile_cnt;
    logic [TILE_CNT_WIDTH-1:0]   tile_num_r;
    logic [PIX_CNT_WIDTH-1:0]    pix_cnt;
    logic [PIX_CNT_WIDTH-1:0]    pix_num_r;
    logic [SHIFT_WIDTH-1:0]      shift_r;
    logic                        relu_r;

    logic signed [ACC_WIDTH-1:0] acc    [OUT_CH];
    logic signed [ACC_WIDTH-1:0] sum_p0 [OUT_CH];
    logic                        beat_p0;
    logic                        last_tile_p0;
    logic                        last_pix_p0;

    logic [OUT_CH*DATA_WIDTH-1:0] data_p1;
    logic                         vld_p1;
    logic                         busy_r;
    logic                         end_r;

    function automatic logic signed [ACC_WIDTH-1:0] sext_psum(input logic [PSUM_WIDTH-1:0] v);
        return {{(ACC_WIDTH-PSUM_WIDTH){v[PSUM_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sext_bias(input logic [BIAS_WIDTH-1:0] v);
        return {{(ACC_WIDTH-BIAS_WIDTH){v[BIAS_WIDTH-1]}}, v};
    endfunction

    // Round-half-up arithmetic shift, optional ReLU, clamp to the signed output range.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] s,
                                                      input logic [SHIFT_WIDTH-1:0]     sh,
                                                      input logic                       relu);
        logic signed [ACC_WIDTH:0] r;
        r = {s[ACC_WIDTH-1], s};
        if (sh != '0)
            r = (r + (RND_ONE <<< (sh - SHIFT_WIDTH'(1)))) >>> sh;
        if (relu && (r < 0))
            r = '0;
        if (r > SAT_MAX)
            r = SAT_MAX;
        else if (r < SAT_MIN)
            r = SAT_MIN;
        return r[DATA_WIDTH-1:0];
    endfunction

    // Stage p0: accepted beat, running sum per channel (bias folded in on the first tile).
    always_comb begin
        beat_p0      = (state == ACCUM) && psum_valid_in;
        last_tile_p0 = (tile_cnt == tile_num_r - TILE_CNT_WIDTH'(1));
        last_pix_p0  = (pix_cnt == pix_num_r - PIX_CNT_WIDTH'(1));
        for (int k = 0; k < OUT_CH; k++) begin
            sum_p0[k] = ((tile_cnt == '0) ? sext_bias(bias_in[k*BIAS_WIDTH +: BIAS_WIDTH]) : acc[k])
                        + sext_psum(psum_in[k*PSUM_WIDTH +: PSUM_WIDTH]);
        end
    end

    // Stage p1: accumulator update and registered requantised output on a pixel's last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < OUT_CH; k++)
                acc[k] <= '0;
            data_p1 <= '0;
        end else if (beat_p0) begin
            for (int k = 0; k < OUT_CH; k++)
                acc[k] <= sum_p0[k];
            if (last_tile_p0) begin
                for (int k = 0; k < OUT_CH; k++)
                    data_p1[k*DATA_WIDTH +: DATA_WIDTH] <= requant(sum_p0[k], shift_r, relu_r);
            end
        end
    end

    // Layer FSM: config latch, tile/pixel counting, valid and completion pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            tile_cnt   <= '0;
            pix_cnt    <= '0;
            tile_num_r <= '0;
            pix_num_r  <= '0;
            shift_r    <= '0;
            relu_r     <= 1'b0;
            vld_p1     <= 1'b0;
            busy_r     <= 1'b0;
            end_r      <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            end_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        tile_num_r <= (cfg_tile_num == '0) ? TILE_CNT_WIDTH'(1) : cfg_tile_num;
                        pix_num_r  <= cfg_pix_num;
                        shift_r    <= cfg_shift;
                        relu_r     <= cfg_relu_en;
                        tile_cnt   <= '0;
                        pix_cnt    <= '0;
                        busy_r     <= 1'b1;
                        if (cfg_pix_num == '0) begin
                            state <= DONE;
                            end_r <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_p0) begin
                        if (last_tile_p0) begin
                            tile_cnt <= '0;
                            pix_cnt  <= pix_cnt + PIX_CNT_WIDTH'(1);
                            vld_p1   <= 1'b1;
                            if (last_pix_p0) begin
                                state <= DONE;
                                end_r <= 1'b1;
                            end
                        end else begin
                            tile_cnt <= tile_cnt + TILE_CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign data_out       = data_p1;
    assign data_valid_out = vld_p1;
    assign busy           = busy_r;
    assign state_end      = end_r;

endmodule

// File: tb/tb_conv_accum_requant.sv
// Bench for conv_accum_requant: randomized layers checked against a per-pixel
// arithmetic model, plus directed cases for rounding, saturation, ReLU,
// empty layers, ignored starts and mid-layer reset.
module tb_conv_accum_requant;

    localparam int OC = 18;
    localparam int PW = 20;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int BW = 16;
    localparam int SW = 5;
    localparam int TW = 8;
    localparam int XW = 16;

    logic               clk;
    logic               rstn;
    logic               cfg_start;
    logic [TW-1:0]      cfg_tile_num;
    logic [XW-1:0]      cfg_pix_num;
    logic [SW-1:0]      cfg_shift;
    logic               cfg_relu_en;
    logic [OC*BW-1:0]   bias_in;
    logic [OC*PW-1:0]   psum_in;
    logic               psum_valid_in;
    logic [OC*DW-1:0]   data_out;
    logic               data_valid_out;
    logic               busy;
    logic               state_end;

    conv_accum_requant #(
        .OUT_CH(OC), .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .DATA_WIDTH(DW),
        .BIAS_WIDTH(BW), .SHIFT_WIDTH(SW), .TILE_CNT_WIDTH(TW), .PIX_CNT_WIDTH(XW)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_tile_num(cfg_tile_num),
        .cfg_pix_num(cfg_pix_num), .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
        .bias_in(bias_in), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .data_out(data_out), .data_valid_out(data_valid_out), .busy(busy), .state_end(state_end)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [OC*DW-1:0] exp_q[$];
    int               vld_cyc[$];
    bit               use_dir = 0;
    bit               inject = 0;
    int               dir_ps0[$];
    int               dir_ps1[$];
    int               dir_bias0 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requantisation rule in plain integer arithmetic.
    function automatic logic [DW-1:0] ref_q(input int s, input int sh, input bit relu);
        longint r;
        r = s;
        if (sh > 0)
            r = (r + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0)
            r = 0;
        if (r > 127)
            r = 127;
        if (r < -128)
            r = -128;
        return DW'(r);
    endfunction

    // Output monitor: every valid pulse must match the oldest expected pixel.
    always @(negedge clk) begin
        if (rstn && data_valid_out) begin
            vld_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                logic [OC*DW-1:0] ev;
                ev = exp_q.pop_front();
                for (int k = 0; k < OC; k++)
                    check($sformatf("data_ch%0d", k), longint'($signed(data_out[k*DW +: DW])),
                          longint'($signed(ev[k*DW +: DW])));
            end
        end
    end

    task automatic run_layer(input int tn, input int pn, input int sh, input bit relu, input int gapmax);
        int tiles;
        int beat;
        int acc[OC];
        int ps;
        int bs;
        logic signed [PW-1:0] r20;
        logic signed [BW-1:0] r16;
        logic [OC*DW-1:0] ev;
        tiles = (tn == 0) ? 1 : tn;
        beat = 0;
        cfg_tile_num = TW'(tn);
        cfg_pix_num = XW'(pn);
        cfg_shift = SW'(sh);
        cfg_relu_en = relu;
        cfg_start = 1'b1;
        psum_valid_in = 1'($urandom_range(0, 1));
        psum_in = {OC{PW'($urandom)}};
        tick();
        cfg_start = 1'b0;
        for (int p = 0; p < pn; p++) begin
            for (int t = 0; t < tiles; t++) begin
                repeat ($urandom_range(0, gapmax)) begin
                    psum_valid_in = 1'b0;
                    psum_in = {OC{PW'($urandom)}};
                    bias_in = {OC{BW'($urandom)}};
                    tick();
                end
                for (int k = 0; k < OC; k++) begin
                    if (use_dir && k == 0) begin
                        ps = (dir_ps0.size() != 0) ? dir_ps0.pop_front() : 0;
                        bs = dir_bias0;
                    end else if (use_dir && k == 1) begin
                        ps = (dir_ps1.size() != 0) ? dir_ps1.pop_front() : 0;
                        bs = 0;
                    end else begin
                        r20 = PW'($urandom);
                        r16 = BW'($urandom);
                        ps = ($urandom_range(0, 2) == 0) ? int'(r20) : int'($urandom_range(0, 600)) - 300;
                        bs = ($urandom_range(0, 1) == 0) ? int'(r16) : int'($urandom_range(0, 100)) - 50;
                    end
                    psum_in[k*PW +: PW] = PW'(ps);
                    bias_in[k*BW +: BW] = BW'(bs);
                    if (t == 0)
                        acc[k] = bs + ps;
                    else
                        acc[k] = acc[k] + ps;
                    ev[k*DW +: DW] = ref_q(acc[k], sh, relu);
                end
                psum_valid_in = 1'b1;
                cfg_tile_num = TW'($urandom);
                cfg_pix_num = XW'($urandom_range(0, 3));
                cfg_shift = SW'($urandom);
                cfg_relu_en = 1'($urandom_range(0, 1));
                if (inject && beat == 1)
                    cfg_start = 1'b1;
                if (t == tiles - 1)
                    exp_q.push_back(ev);
                beat++;
                tick();
                cfg_start = 1'b0;
            end
        end
        psum_valid_in = 1'b0;
        @(negedge clk);
        check("end_pulse", state_end, 1);
        check("end_valid", data_valid_out, (pn > 0) ? 1 : 0);
        check("end_busy", busy, 1);
        @(negedge clk);
        check("busy_drop", busy, 0);
        check("end_once", state_end, 0);
        check("queue_empty", exp_q.size(), 0);
        tick();
        psum_valid_in = 1'b1;
        tick();
        tick();
        psum_valid_in = 1'b0;
    endtask

    initial begin
        int rv[3];
        int re[3];
        rv = '{-6, 6, 5};
        re = '{-1, 2, 1};
        rstn = 1'b0;
        cfg_start = 1'b0;
        cfg_tile_num = '0;
        cfg_pix_num = '0;
        cfg_shift = '0;
        cfg_relu_en = 1'b0;
        bias_in = '0;
        psum_in = '0;
        psum_valid_in = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid_out, 0);
        check("rst_end", state_end, 0);
        check("rst_data_nonzero", longint'(data_out != '0), 0);
        rstn = 1'b1;
        tick();

        // Three tiles with bias: 10+100+200-50 = 260, shift 2 -> 65.
        use_dir = 1;
        dir_ps0 = '{100, 200, -50};
        dir_bias0 = 10;
        run_layer(3, 1, 2, 0, 1);
        check("tile3_ch0", longint'($signed(data_out[DW-1:0])), 65);

        // Saturation both ways, then ReLU clamps the negative side.
        dir_bias0 = 0;
        dir_ps0 = '{1000};
        dir_ps1 = '{-1000};
        run_layer(1, 1, 0, 0, 0);
        check("sat_hi_ch0", longint'($signed(data_out[DW-1:0])), 127);
        check("sat_lo_ch1", longint'($signed(data_out[2*DW-1:DW])), -128);
        dir_ps0 = '{1000};
        dir_ps1 = '{-1000};
        run_layer(1, 1, 0, 1, 0);
        check("relu_ch0", longint'($signed(data_out[DW-1:0])), 127);
        check("relu_ch1", longint'($signed(data_out[2*DW-1:DW])), 0);

        // Rounding half up on shift 2.
        for (int i = 0; i < 3; i++) begin
            dir_ps0.push_back(rv[i]);
            run_layer(1, 1, 2, 0, 0);
            check($sformatf("round_%0d", rv[i]), longint'($signed(data_out[DW-1:0])), re[i]);
        end

        // Reset after the first of three tiles abandons the pixel.
        dir_ps0.delete();
        cfg_tile_num = 3;
        cfg_pix_num = 2;
        cfg_shift = 2;
        cfg_relu_en = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        psum_valid_in = 1'b1;
        psum_in = {OC{PW'(12345)}};
        bias_in = {OC{BW'(77)}};
        tick();
        psum_valid_in = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid_rst_data", longint'(data_out != '0), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", data_valid_out, 0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", busy, 0);
        dir_ps0 = '{100, 200, -50};
        dir_bias0 = 10;
        run_layer(3, 1, 2, 0, 0);
        check("post_rst_ch0", longint'($signed(data_out[DW-1:0])), 65);
        use_dir = 0;

        // Continuous valid, 4 pixels of 2 tiles: pulses every other cycle.
        vld_cyc.delete();
        run_layer(2, 4, 3, 0, 0);
        check("pulse_count", vld_cyc.size(), 4);
        for (int i = 1; i < vld_cyc.size(); i++)
            check($sformatf("pulse_gap%0d", i), vld_cyc[i] - vld_cyc[i-1], 2);

        // Empty layer: completion only, no data.
        vld_cyc.delete();
        run_layer(2, 0, 3, 0, 0);
        check("empty_no_valid", vld_cyc.size(), 0);

        // A start pulse during the layer must not disturb it.
        inject = 1;
        run_layer(2, 3, 4, 1, 1);
        inject = 0;

        // Randomized layers, including tile_num 0 and wide shifts.
        for (int n = 0; n < 14; n++)
            run_layer($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 10), 1'($urandom_range(0, 1)), 2);

        check("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
